mem_port_arbiter: RTL and testbench

Shares the single-ported main memory between the instruction-fetch path and the load/store path of the multi-cycle CPU. Accepts one request at a time from either requester, with round-robin on simultaneous requests. Drives the memory with a hold-until-ready handshake and returns read data with a one-cycle completion pulse. Aborts with an error if the memory does not answer within a bounded number of cycles.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, owner
// encoding, default bus widths and the round-robin pick.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Choose the requester to serve. On a tie the port that was not served
  // last wins. The caller only uses the result when a request is present.
  function automatic owner_t rr_pick(input logic if_req, input logic ls_req,
                                     input owner_t last_grant);
    if (if_req && ls_req)
      return (last_grant == OWN_LS) ? OWN_IF : OWN_LS;
    else if (ls_req)
      return OWN_LS;
    else
      return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the view of the surrounding
// CPU and memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] rd_data;
  logic              err;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
    output if_done, ls_done, rd_data, err, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
    input  if_done, ls_done, rd_data, err, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One access at a time, round-robin on ties, hold-until-ready handshake,
// bounded wait with an error completion. Every output comes from a register.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next;
  owner_t            last_grant_reg, last_grant_next;
  owner_t            grant;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic              if_done_reg, if_done_next;
  logic              ls_done_reg, ls_done_next;

  // FSM state register; reset drops any access in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    grant           = OWN_IF;
    cnt_next        = cnt_reg;
    mem_en_next     = mem_en_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    rd_data_next    = rd_data_reg;
    err_next        = err_reg;
    busy_next       = busy_reg;
    if_done_next    = 1'b0;
    ls_done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          grant          = rr_pick(bus.if_req, bus.ls_req, last_grant_reg);
          owner_next     = grant;
          mem_en_next    = 1'b1;
          mem_we_next    = (grant == OWN_LS) && bus.ls_we;
          mem_addr_next  = (grant == OWN_LS) ? bus.ls_addr : bus.if_addr;
          mem_wdata_next = (grant == OWN_LS) ? bus.ls_wdata : '0;
          cnt_next       = '0;
          busy_next      = 1'b1;
          err_next       = 1'b0;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          if (!mem_we_reg) rd_data_next = bus.mem_rdata;
          err_next     = 1'b0;
          mem_en_next  = 1'b0;
          if_done_next = (owner_reg == OWN_IF);
          ls_done_next = (owner_reg == OWN_LS);
          state_next   = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          // Memory never answered: complete with an error and no data.
          rd_data_next = '0;
          err_next     = 1'b1;
          mem_en_next  = 1'b0;
          if_done_next = (owner_reg == OWN_IF);
          ls_done_next = (owner_reg == OWN_LS);
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        last_grant_next = owner_reg;
        busy_next       = 1'b0;
        err_next        = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= OWN_IF;
      last_grant_reg <= OWN_LS;
      cnt_reg        <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      rd_data_reg    <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      if_done_reg    <= 1'b0;
      ls_done_reg    <= 1'b0;
    end else begin
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      rd_data_reg    <= rd_data_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
      if_done_reg    <= if_done_next;
      ls_done_reg    <= ls_done_next;
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = busy_reg;
  assign bus.if_done   = if_done_reg;
  assign bus.ls_done   = ls_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue of expected
// completions, a memory model with configurable wait states, and a monitor
// that records each mem_en window.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: answers after wait_cfg wait cycles unless no_ready is set.
  int   wait_cfg = 0;
  logic no_ready = 1'b0;
  int   wait_cnt = 0;

  function automatic logic [31:0] mem_model(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {~a, a};
  endfunction

  always @(posedge clk) wait_cnt <= bus.mem_en ? wait_cnt + 1 : 0;
  assign bus.mem_ready = bus.mem_en && !no_ready && (wait_cnt == wait_cfg);
  assign bus.mem_rdata = mem_model(bus.mem_addr);

  // Monitor: length of each mem_en window and stability of its fields.
  int          en_cnt = 0;
  logic        prev_en = 1'b0;
  logic [15:0] en_addr = '0;
  logic        en_we = 1'b0;
  logic [31:0] en_wdata = '0;
  logic        en_stable = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (!prev_en) begin
        en_cnt    <= 1;
        en_addr   <= bus.mem_addr;
        en_we     <= bus.mem_we;
        en_wdata  <= bus.mem_wdata;
        en_stable <= 1'b1;
      end else begin
        en_cnt <= en_cnt + 1;
        if (bus.mem_addr !== en_addr || bus.mem_we !== en_we || bus.mem_wdata !== en_wdata)
          en_stable <= 1'b0;
      end
    end
    prev_en <= bus.mem_en;
  end

  typedef struct {
    logic        own;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          en;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic own, input logic we, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic tmo, input int waits);
    exp_t e;
    e.own   = own;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = tmo;
    e.en    = tmo ? TIMEOUT : waits + 1;
    if (tmo)      model_rd = '0;
    else if (!we) model_rd = mem_model(addr);
    e.rd = model_rd;
    sb.push_back(e);
  endtask

  task automatic req_if(input logic [15:0] addr);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
  endtask

  task automatic req_ls(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    bus.ls_we    = we;
    bus.ls_addr  = addr;
    bus.ls_wdata = wdata;
    bus.ls_req   = 1'b1;
  endtask

  // Wait (bounded) for a done pulse, compare it to the scoreboard head,
  // release that requester, then step into the following IDLE cycle.
  task automatic wait_done(input int limit, output int cycles);
    exp_t e;
    cycles = 0;
    while (!(bus.if_done || bus.ls_done) && cycles < limit) begin
      tick();
      cycles++;
    end
    chk("done_seen", {31'b0, bus.if_done | bus.ls_done}, 32'd1);
    if (!(bus.if_done || bus.ls_done)) return;
    chk("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    $display("txn own=%s addr=%h we=%0d rd_data=%h err=%0d en_cycles=%0d",
             e.own ? "LS" : "IF", e.addr, e.we, bus.rd_data, bus.err, en_cnt);
    chk("ls_done", {31'b0, bus.ls_done}, {31'b0, e.own});
    chk("if_done", {31'b0, bus.if_done}, {31'b0, ~e.own});
    chk("rd_data", bus.rd_data, e.rd);
    chk("err", {31'b0, bus.err}, {31'b0, e.err});
    chk("busy_in_done", {31'b0, bus.busy}, 32'd1);
    chk("mem_en_cycles", en_cnt, e.en);
    chk("mem_addr", {16'b0, en_addr}, {16'b0, e.addr});
    chk("mem_we", {31'b0, en_we}, {31'b0, e.we});
    if (e.we) chk("mem_wdata", en_wdata, e.wdata);
    chk("mem_fields_stable", {31'b0, en_stable}, 32'd1);
    if (e.own) bus.ls_req = 1'b0;
    else       bus.if_req = 1'b0;
    tick();
    chk("done_one_cycle", {30'b0, bus.if_done, bus.ls_done}, 32'd0);
    chk("busy_idle", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;

    // Reset values.
    tick();
    tick();
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_dones", {30'b0, bus.if_done, bus.ls_done}, 32'd0);
    reset = 1'b0;
    tick();

    // Fetch only, zero wait: mem_en in cycle 1, done in cycle 2.
    wait_cfg = 0;
    req_if(16'h0010);
    push(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, 0);
    tick();
    chk("t1_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("t1_mem_addr", {16'b0, bus.mem_addr}, 32'h0010);
    chk("t1_mem_we", {31'b0, bus.mem_we}, 32'd0);
    wait_done(10, cyc);
    chk("t1_latency", cyc + 1, 32'd2);

    // Store with three wait cycles; rd_data must keep the earlier read.
    wait_cfg = 3;
    req_ls(1'b1, 16'h0200, 32'h12345678);
    push(1'b1, 1'b1, 16'h0200, 32'h12345678, 1'b0, 3);
    wait_done(20, cyc);
    chk("t2_latency", cyc, 32'd5);

    // Simultaneous requests: grants must alternate IF, LS, IF, LS.
    wait_cfg = 0;
    req_if(16'h0100);
    req_ls(1'b0, 16'h0300, 32'h0);
    push(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 0);
    push(1'b1, 1'b0, 16'h0300, 32'h0, 1'b0, 0);
    wait_done(10, cyc);
    req_if(16'h0104);
    push(1'b0, 1'b0, 16'h0104, 32'h0, 1'b0, 0);
    wait_done(10, cyc);
    req_ls(1'b0, 16'h0304, 32'h0);
    push(1'b1, 1'b0, 16'h0304, 32'h0, 1'b0, 0);
    wait_done(10, cyc);
    wait_done(10, cyc);

    // Timeout: memory never ready; then a normal access.
    no_ready = 1'b1;
    req_if(16'h0030);
    push(1'b0, 1'b0, 16'h0030, 32'h0, 1'b1, 0);
    wait_done(40, cyc);
    chk("t4_timeout_latency", cyc, 32'd16);
    no_ready = 1'b0;
    req_ls(1'b0, 16'h0044, 32'h0);
    push(1'b1, 1'b0, 16'h0044, 32'h0, 1'b0, 0);
    wait_done(10, cyc);

    // Load/store request arrives while a fetch is in ACCESS.
    wait_cfg = 1;
    req_if(16'h0060);
    push(1'b0, 1'b0, 16'h0060, 32'h0, 1'b0, 1);
    tick();
    req_ls(1'b0, 16'h0070, 32'h0);
    push(1'b1, 1'b0, 16'h0070, 32'h0, 1'b0, 1);
    wait_done(10, cyc);
    wait_done(10, cyc);
    chk("t5_ls_after_done", cyc, 32'd3);

    // Reset in the middle of an access.
    no_ready = 1'b1;
    req_if(16'h0050);
    tick();
    tick();
    chk("t6_mem_en_before", {31'b0, bus.mem_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_mem_en_async", {31'b0, bus.mem_en}, 32'd0);
    chk("t6_busy_async", {31'b0, bus.busy}, 32'd0);
    bus.if_req = 1'b0;
    model_rd = '0;
    tick();
    chk("t6_no_done", {30'b0, bus.if_done, bus.ls_done}, 32'd0);
    reset = 1'b0;
    no_ready = 1'b0;
    wait_cfg = 0;
    tick();
    req_if(16'h0010);
    push(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, 0);
    tick();
    chk("t6_mem_en_cycle1", {31'b0, bus.mem_en}, 32'd1);
    wait_done(10, cyc);
    chk("t6_latency", cyc + 1, 32'd2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
